// File: rtl/macc_mm.sv
// Matrix-multiply accelerator: A, B and C live in three RAMs with host streaming
// counters; a read/multiply/accumulate pipeline computes C = A x B one MAC per cycle.
module macc_mm #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 6
) (
  input  logic              CLK,
  input  logic              RST_L,
  input  logic [2:0]        wen,
  input  logic [2:0]        ren,
  input  logic              rewind,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DATA_W-1:0] matrix_a_in,
  input  logic [DATA_W-1:0] matrix_b_in,
  input  logic [DATA_W-1:0] matrix_c_in,
  output logic [DATA_W-1:0] matrix_a_out,
  output logic [DATA_W-1:0] matrix_b_out,
  output logic [DATA_W-1:0] matrix_c_out,
  output logic [2:0]        rd_valid,
  input  logic              start,
  output logic              busy,
  output logic              done
);

  localparam int ADDR_W = 2 * DIM_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;
  logic   done_nxt;

  logic signed [DATA_W-1:0] mem_a [DEPTH];
  logic signed [DATA_W-1:0] mem_b [DEPTH];
  logic signed [DATA_W-1:0] mem_c [DEPTH];

  logic [ADDR_W-1:0] ptr_a, ptr_b, ptr_c;
  logic              host_ok;
  logic [2:0]        host_we, host_re;

  logic [DIM_W-1:0]  lat_m, lat_k, lat_n;
  logic [DIM_W-1:0]  eng_i, eng_j, eng_kk;
  logic              start_acc, run, issue_last;

  logic                     vld_p0, first_p0, wr_p0, last_p0;
  logic [ADDR_W-1:0]        caddr_p0;
  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic                     vld_p1, first_p1, wr_p1, last_p1;
  logic [ADDR_W-1:0]        caddr_p1;
  logic signed [DATA_W-1:0] prod_p1;
  logic signed [DATA_W-1:0] acc_p2, acc_sum;
  logic                     c_eng_we;

  // Products wrap modulo 2^DATA_W: only the low half of the product is kept.
  function automatic logic signed [DATA_W-1:0] mul_wrap(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a * b;
  endfunction

  // Row-major step over a (rmax+1) x (cmax+1) shape, wrapping to {0,0}.
  function automatic logic [ADDR_W-1:0] adv(
    input logic [ADDR_W-1:0] p,
    input logic [DIM_W-1:0]  rmax,
    input logic [DIM_W-1:0]  cmax
  );
    logic [DIM_W-1:0] r, c;
    r = p[ADDR_W-1:DIM_W];
    c = p[DIM_W-1:0];
    if (c == cmax) begin
      c = '0;
      if (r == rmax) r = '0;
      else           r = r + DIM_W'(1);
    end else begin
      c = c + DIM_W'(1);
    end
    return {r, c};
  endfunction

  assign start_acc  = (state == IDLE) && start;
  assign host_ok    = (state == IDLE) && !start;
  assign host_we    = wen & {3{host_ok}};
  assign host_re    = ren & {3{host_ok}};
  assign run        = (state == RUN);
  assign issue_last = (eng_i == lat_m) && (eng_j == lat_n) && (eng_kk == lat_k);

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (vld_p1 && last_p1) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Host streaming counters; rewind beats any advance in the same cycle.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      ptr_a <= '0;
      ptr_b <= '0;
      ptr_c <= '0;
    end else if (rewind) begin
      ptr_a <= '0;
      ptr_b <= '0;
      ptr_c <= '0;
    end else begin
      if (host_we[2] || host_re[2]) ptr_a <= adv(ptr_a, dim_m, dim_k);
      if (host_we[1] || host_re[1]) ptr_b <= adv(ptr_b, dim_k, dim_n);
      if (host_we[0] || host_re[0]) ptr_c <= adv(ptr_c, dim_m, dim_n);
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      rd_valid     <= '0;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
      matrix_c_out <= '0;
    end else begin
      rd_valid <= host_re;
      if (host_re[2]) matrix_a_out <= mem_a[ptr_a];
      if (host_re[1]) matrix_b_out <= mem_b[ptr_b];
      if (host_re[0]) matrix_c_out <= mem_c[ptr_c];
    end
  end

  always_ff @(posedge CLK) begin
    if (host_we[2]) mem_a[ptr_a] <= matrix_a_in;
    if (host_we[1]) mem_b[ptr_b] <= matrix_b_in;
  end

  // Engine walk: kk fastest, then j, then i; dims frozen at start.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      lat_m  <= '0;
      lat_k  <= '0;
      lat_n  <= '0;
      eng_i  <= '0;
      eng_j  <= '0;
      eng_kk <= '0;
    end else if (start_acc) begin
      lat_m  <= dim_m;
      lat_k  <= dim_k;
      lat_n  <= dim_n;
      eng_i  <= '0;
      eng_j  <= '0;
      eng_kk <= '0;
    end else if (run) begin
      if (eng_kk == lat_k) begin
        eng_kk <= '0;
        if (eng_j == lat_n) begin
          eng_j <= '0;
          eng_i <= eng_i + DIM_W'(1);
        end else begin
          eng_j <= eng_j + DIM_W'(1);
        end
      end else begin
        eng_kk <= eng_kk + DIM_W'(1);
      end
    end
  end

  // Stage p0: RAM read of A[i][kk] and B[kk][j].
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      wr_p0    <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      vld_p0   <= run;
      first_p0 <= (eng_kk == '0);
      wr_p0    <= (eng_kk == lat_k);
      last_p0  <= issue_last;
    end
  end

  always_ff @(posedge CLK) begin
    if (run) begin
      a_p0     <= mem_a[{eng_i, eng_kk}];
      b_p0     <= mem_b[{eng_kk, eng_j}];
      caddr_p0 <= {eng_i, eng_j};
    end
  end

  // Stage p1: registered product.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      wr_p1    <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      wr_p1    <= wr_p0;
      last_p1  <= last_p0;
    end
  end

  always_ff @(posedge CLK) begin
    if (vld_p0) begin
      prod_p1  <= mul_wrap(a_p0, b_p0);
      caddr_p1 <= caddr_p0;
    end
  end

  // Stage p2: accumulate, restarting on kk=0, and write C on the last term.
  assign acc_sum  = first_p1 ? prod_p1 : acc_p2 + prod_p1;
  assign c_eng_we = vld_p1 && wr_p1;

  always_ff @(posedge CLK) begin
    if (vld_p1) acc_p2 <= acc_sum;
  end

  always_ff @(posedge CLK) begin
    if (c_eng_we)        mem_c[caddr_p1] <= acc_sum;
    else if (host_we[0]) mem_c[ptr_c]    <= matrix_c_in;
  end

endmodule

// File: tb/tb_macc_mm.sv
// Directed bench for macc_mm: golden matrix products go to a scoreboard queue and
// are popped as C is streamed back out.
module tb_macc_mm;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 6;

  logic              CLK, RST_L;
  logic [2:0]        wen, ren;
  logic              rewind;
  logic [DIM_W-1:0]  dim_m, dim_k, dim_n;
  logic [DATA_W-1:0] matrix_a_in, matrix_b_in, matrix_c_in;
  logic [DATA_W-1:0] matrix_a_out, matrix_b_out, matrix_c_out;
  logic [2:0]        rd_valid;
  logic              start, busy, done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int d0;
  logic [DATA_W-1:0] ga [64];
  logic [DATA_W-1:0] gb [64];
  logic [DATA_W-1:0] sb [$];

  macc_mm #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .CLK(CLK), .RST_L(RST_L), .wen(wen), .ren(ren), .rewind(rewind),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .matrix_a_in(matrix_a_in), .matrix_b_in(matrix_b_in), .matrix_c_in(matrix_c_in),
    .matrix_a_out(matrix_a_out), .matrix_b_out(matrix_b_out), .matrix_c_out(matrix_c_out),
    .rd_valid(rd_valid), .start(start), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (done) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_dims(input int m, input int k, input int n);
    dim_m = DIM_W'(m);
    dim_k = DIM_W'(k);
    dim_n = DIM_W'(n);
  endtask

  task automatic pulse_rewind();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
  endtask

  task automatic wr(input int mat, input logic [DATA_W-1:0] d);
    wen = 3'b000;
    wen[mat] = 1'b1;
    case (mat)
      2:       matrix_a_in = d;
      1:       matrix_b_in = d;
      default: matrix_c_in = d;
    endcase
    tick();
    wen = 3'b000;
  endtask

  function automatic logic [DATA_W-1:0] out_of(input int mat);
    case (mat)
      2:       return matrix_a_out;
      1:       return matrix_b_out;
      default: return matrix_c_out;
    endcase
  endfunction

  task automatic rd_check(input int mat, input string tag);
    logic [DATA_W-1:0] expv;
    ren = 3'b000;
    ren[mat] = 1'b1;
    tick();
    ren = 3'b000;
    check({tag, "_vld"}, 32'(rd_valid[mat]), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      expv = sb.pop_front();
      check(tag, out_of(mat), expv);
    end
  endtask

  task automatic load_ab(input int m, input int k, input int n);
    set_dims(m, k, n);
    pulse_rewind();
    for (int x = 0; x < (m + 1) * (k + 1); x++) wr(2, ga[x]);
    for (int x = 0; x < (k + 1) * (n + 1); x++) wr(1, gb[x]);
  endtask

  task automatic push_golden(input int m, input int k, input int n);
    logic [DATA_W-1:0] s;
    for (int i = 0; i <= m; i++) begin
      for (int j = 0; j <= n; j++) begin
        s = '0;
        for (int kk = 0; kk <= k; kk++) s = s + ga[i * (k + 1) + kk] * gb[kk * (n + 1) + j];
        sb.push_back(s);
      end
    end
  endtask

  task automatic run_job(input int m, input int k, input int n, input bit disturb, input string tag);
    int lat;
    bit seen;
    int exp_lat;
    exp_lat = (m + 1) * (k + 1) * (n + 1) + 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (disturb && lat >= 3 && lat <= 5) begin
          wen = 3'b001;
          ren = 3'b100;
          start = 1'b1;
          matrix_c_in = 32'hDEAD_BEEF;
        end else begin
          wen = 3'b000;
          ren = 3'b000;
          start = 1'b0;
        end
        tick();
        lat++;
        if (disturb) check({tag, "_rdvalid_busy"}, 32'(rd_valid), 32'd0);
      end
    end
    wen = 3'b000;
    ren = 3'b000;
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    RST_L = 1'b0;
    wen = '0;
    ren = '0;
    rewind = 1'b0;
    start = 1'b0;
    matrix_a_in = '0;
    matrix_b_in = '0;
    matrix_c_in = '0;
    set_dims(0, 0, 0);
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_a_out", matrix_a_out, 32'd0);
    check("rst_b_out", matrix_b_out, 32'd0);
    check("rst_c_out", matrix_c_out, 32'd0);
    RST_L = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // 2x2 square product
    for (int x = 0; x < 4; x++) begin
      ga[x] = 32'(x + 1);
      gb[x] = 32'(x + 5);
    end
    load_ab(1, 1, 1);
    sb.push_back(32'd19);
    sb.push_back(32'd22);
    sb.push_back(32'd43);
    sb.push_back(32'd50);
    run_job(1, 1, 1, 1'b0, "mm2x2");
    pulse_rewind();
    for (int x = 0; x < 4; x++) rd_check(0, "mm2x2_c");

    // 1x1 with modulo wrap
    ga[0] = 32'hFFFF_FFFF;
    gb[0] = 32'd2;
    load_ab(0, 0, 0);
    sb.push_back(32'hFFFF_FFFE);
    run_job(0, 0, 0, 1'b0, "mm1x1");
    pulse_rewind();
    rd_check(0, "mm1x1_c");

    // Non-square (2x3)(3x1), then 7th A write wraps to {0,0}
    for (int x = 0; x < 6; x++) ga[x] = 32'(x + 1);
    for (int x = 0; x < 3; x++) gb[x] = 32'd1;
    load_ab(1, 2, 0);
    sb.push_back(32'd6);
    sb.push_back(32'd15);
    run_job(1, 2, 0, 1'b0, "mm_ns");
    rd_check(0, "mm_ns_c");
    rd_check(0, "mm_ns_c");
    wr(2, 32'h77);
    pulse_rewind();
    sb.push_back(32'h77);
    rd_check(2, "a_wrap");

    // Read-first on simultaneous wen/ren, single advance
    pulse_rewind();
    wen = 3'b010;
    ren = 3'b010;
    matrix_b_in = 32'hAB;
    tick();
    wen = 3'b000;
    ren = 3'b000;
    check("b_rw_vld", 32'(rd_valid), 32'b010);
    check("b_rw_old", matrix_b_out, 32'd1);
    wr(1, 32'hCD);
    pulse_rewind();
    sb.push_back(32'hAB);
    sb.push_back(32'hCD);
    sb.push_back(32'd1);
    for (int x = 0; x < 3; x++) rd_check(1, "b_after_rw");
    tick();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);
    check("b_out_hold", matrix_b_out, 32'd1);

    // rewind together with wen leaves the counter at 0
    pulse_rewind();
    wr(1, 32'h11);
    rewind = 1'b1;
    wen = 3'b010;
    matrix_b_in = 32'hEE;
    tick();
    rewind = 1'b0;
    wen = 3'b000;
    sb.push_back(32'h11);
    rd_check(1, "rewind_wen");

    // Host strobes and a second start are ignored while busy
    for (int x = 0; x < 4; x++) begin
      ga[x] = 32'(x + 1);
      gb[x] = 32'(x + 5);
    end
    load_ab(1, 1, 1);
    push_golden(1, 1, 1);
    d0 = done_cnt;
    run_job(1, 1, 1, 1'b1, "busy_ign");
    repeat (3) tick();
    check("busy_ign_done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_ign_idle", 32'(busy), 32'd0);
    for (int x = 0; x < 4; x++) rd_check(0, "busy_ign_c");

    // Reset mid-run, then a fresh job
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    RST_L = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_b_out", matrix_b_out, 32'd0);
    check("mid_rst_c_out", matrix_c_out, 32'd0);
    #2;
    RST_L = 1'b1;
    tick();
    ga[0] = 32'd2; ga[1] = 32'd3; ga[2] = 32'd5; ga[3] = 32'd7;
    gb[0] = 32'd1; gb[1] = 32'd1; gb[2] = 32'd2; gb[3] = 32'd0;
    load_ab(1, 1, 1);
    push_golden(1, 1, 1);
    run_job(1, 1, 1, 1'b0, "post_rst");
    pulse_rewind();
    for (int x = 0; x < 4; x++) rd_check(0, "post_rst_c");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
